pea_invoke_scheduler: RTL and testbench
=======================================

// Module: pea_invoke_scheduler
// PURPOSE
//  Synthesizable CFDF firing scheduler for the PEA actor; replaces hand-sequenced invoke/next_instr driving.
//  Accepts queued firing descriptors (mode + repeat count), drives next_mode, waits for PEA_enable,
//  pulses invoke, then waits for the firing-complete (FC) edge, with timeout, abort and firing statistics.
//  Sits between the host/controller and PEA_top_module_1 / PEA_enable.
// PARAMETERS
//  DESC_DEPTH  4     descriptor queue depth, power of 2, >=2
//  CNT_W       8     width of per-descriptor repeat count
//  TIMEOUT     1024  max cycles in WAIT_FC before error; 0 disables timeout
//  FIRE_CNT_W  16    width of firing_count
// PORTS
//  clk          in   1           clock
//  rst          in   1           synchronous reset, active-high
//  desc_valid   in   1           descriptor offered
//  desc_ready   out  1           queue not full; push on desc_valid&desc_ready at clk edge
//  desc_mode    in   2           00 SETUP_INSTR, 01 INSTR, 10 OUTPUT, 11 reserved
//  desc_count   in   CNT_W       number of firings for this descriptor
//  enable       in   1           from PEA_enable, combinational on next_mode
//  fc           in   1           firing complete from actor (pulse or level; rising edge counts)
//  abort        in   1           flush queue and current descriptor
//  err_clr      in   1           clears timeout_err/bad_desc, leaves ERROR
//  next_mode    out  2           mode presented to actor/enable logic
//  invoke       out  1           one-cycle firing request
//  busy         out  1           state!=IDLE or queue non-empty
//  firing_count out  FIRE_CNT_W  completed firings, saturating
//  timeout_err  out  1           sticky: FC not seen within TIMEOUT
//  bad_desc     out  1           sticky: reserved mode accepted
// BEHAVIOUR
//  Reset (rst high at edge): state IDLE, queue empty, next_mode=00, invoke=0, firing_count=0,
//   timeout_err=0, bad_desc=0, desc_ready=1, busy=0. Applies from any state.
//  All outputs registered or decoded from registered state.
//  FSM: IDLE -> SETTLE -> WAIT_EN -> INVOKE -> WAIT_FC -> (SETTLE | IDLE); ERROR.
//   IDLE: queue non-empty -> pop, latch mode/count, next_mode<=mode, go SETTLE.
//    count==0 -> pop, discard, stay IDLE. mode==11 -> pop, discard, bad_desc<=1.
//   SETTLE: one cycle for enable/FIFO counts to settle; -> WAIT_EN.
//   WAIT_EN: enable sampled each edge; high -> INVOKE. No timeout here.
//   INVOKE: invoke=1 for exactly this one cycle; -> WAIT_FC, timer cleared.
//   WAIT_FC: fc_q registered every cycle; edge = fc&!fc_q. On edge: firing_count+1 (saturate),
//    remaining-1; remaining>0 -> SETTLE, else -> IDLE. Timer reaching TIMEOUT (TIMEOUT!=0) -> ERROR.
//   ERROR: timeout_err=1, invoke=0, queue held. err_clr -> IDLE; remaining firings of the current
//    descriptor abandoned; queued descriptors kept.
//  Latency: descriptor accepted at edge t, enable already high -> invoke high in cycle t+3..t+4.
//  Queue: FIFO order, push ignored when full (desc_ready=0). Push+pop in same cycle allowed when not full.
//   Descriptor pushed into empty queue is poppable on the following edge.
//  abort (any state): next edge -> IDLE, queue emptied, invoke=0, push in the same cycle dropped;
//   firing_count and sticky flags kept.
//  err_clr and abort together: abort wins, flags cleared.
//  fc edges outside WAIT_FC are ignored (not counted).
//  next_mode holds last mode in IDLE/ERROR.
// TESTING
//  1 push {01,1}, enable=1, fc pulse 5 cycles after invoke -> one invoke 3 cycles after accept,
//    next_mode=01, firing_count=1, busy=0 after.
//  2 push {00,3}, fc held high between firings then dropped/raised -> 3 invokes, count=3,
//    each only after a new fc edge.
//  3 push {10,1}, enable low 10 cycles then high -> invoke 1 cycle after enable sampled high, never before.
//  4 TIMEOUT=16, no fc -> timeout_err=1 16 cycles into WAIT_FC, no invoke; err_clr -> queued {01,1} runs.
//  5 push 5 descriptors while busy -> desc_ready=0 at 4 queued; {11,2} -> bad_desc=1, 0 invokes;
//    {01,0} skipped.
//  6 abort in WAIT_FC with 2 queued -> IDLE, busy=0, no further invoke; rst in WAIT_EN -> all reset values.

Source files
------------

// File: rtl/pea_invoke_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : pea_invoke_scheduler
// Brief   : CFDF firing scheduler for the PEA actor: queued descriptors drive
//           next_mode, wait for enable, pulse invoke and track firing-complete.
// Revision: 1.0 - initial release
// ============================================================================
module pea_invoke_scheduler #(
    parameter int DESC_DEPTH = 4,
    parameter int CNT_W      = 8,
    parameter int TIMEOUT    = 1024,
    parameter int FIRE_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  desc_valid,
    output logic                  desc_ready,
    input  logic [1:0]            desc_mode,
    input  logic [CNT_W-1:0]      desc_count,
    input  logic                  enable,
    input  logic                  fc,
    input  logic                  abort,
    input  logic                  err_clr,
    output logic [1:0]            next_mode,
    output logic                  invoke,
    output logic                  busy,
    output logic [FIRE_CNT_W-1:0] firing_count,
    output logic                  timeout_err,
    output logic                  bad_desc
);

    localparam int PTR_W = $clog2(DESC_DEPTH);
    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] c_TMR_LAST = TMR_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [PTR_W:0]   c_FULL_LVL = (PTR_W + 1)'(DESC_DEPTH);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_SETTLE  = 3'd1;
    localparam logic [2:0] c_ST_WAIT_EN = 3'd2;
    localparam logic [2:0] c_ST_INVOKE  = 3'd3;
    localparam logic [2:0] c_ST_WAIT_FC = 3'd4;
    localparam logic [2:0] c_ST_ERROR   = 3'd5;

    logic [CNT_W+1:0]      r_q [DESC_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W:0]        r_level;
    logic [2:0]            r_state;
    logic [1:0]            r_mode;
    logic [CNT_W-1:0]      r_remaining;
    logic [TMR_W-1:0]      r_timer;
    logic                  r_fc_q;
    logic [FIRE_CNT_W-1:0] r_firing_count;
    logic                  r_timeout_err;
    logic                  r_bad_desc;

    logic                  w_full;
    logic                  w_empty;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_fc_edge;
    logic [1:0]            w_head_mode;
    logic [CNT_W-1:0]      w_head_cnt;

    assign w_full      = (r_level == c_FULL_LVL);
    assign w_empty     = (r_level == '0);
    assign w_push      = desc_valid && !w_full && !abort;
    assign w_pop       = (r_state == c_ST_IDLE) && !w_empty && !abort;
    assign w_fc_edge   = fc && !r_fc_q;
    assign w_head_mode = r_q[r_rd_ptr][CNT_W+1:CNT_W];
    assign w_head_cnt  = r_q[r_rd_ptr][CNT_W-1:0];

    assign desc_ready   = !w_full;
    assign next_mode    = r_mode;
    assign invoke       = (r_state == c_ST_INVOKE);
    assign busy         = (r_state != c_ST_IDLE) || !w_empty;
    assign firing_count = r_firing_count;
    assign timeout_err  = r_timeout_err;
    assign bad_desc     = r_bad_desc;

    // Storage needs no reset: occupancy is tracked solely by r_level.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_q[r_wr_ptr] <= {desc_mode, desc_count};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr       <= '0;
            r_rd_ptr       <= '0;
            r_level        <= '0;
            r_state        <= c_ST_IDLE;
            r_mode         <= 2'b00;
            r_remaining    <= '0;
            r_timer        <= '0;
            r_fc_q         <= 1'b0;
            r_firing_count <= '0;
            r_timeout_err  <= 1'b0;
            r_bad_desc     <= 1'b0;
        end else begin
            r_fc_q <= fc;
            if (abort) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
                r_level  <= '0;
                r_state  <= c_ST_IDLE;
                if (err_clr) begin
                    r_timeout_err <= 1'b0;
                    r_bad_desc    <= 1'b0;
                end
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_push && !w_pop)      r_level <= r_level + 1'b1;
                else if (!w_push && w_pop) r_level <= r_level - 1'b1;

                // Clear first so a flag raised in the same cycle still sticks.
                if (err_clr) begin
                    r_timeout_err <= 1'b0;
                    r_bad_desc    <= 1'b0;
                end

                case (r_state)
                    c_ST_IDLE: begin
                        if (!w_empty) begin
                            if (w_head_mode == 2'b11) begin
                                r_bad_desc <= 1'b1;
                            end else if (w_head_cnt != '0) begin
                                r_mode      <= w_head_mode;
                                r_remaining <= w_head_cnt;
                                r_state     <= c_ST_SETTLE;
                            end
                        end
                    end
                    c_ST_SETTLE:  r_state <= c_ST_WAIT_EN;
                    c_ST_WAIT_EN: if (enable) r_state <= c_ST_INVOKE;
                    c_ST_INVOKE: begin
                        r_timer <= '0;
                        r_state <= c_ST_WAIT_FC;
                    end
                    c_ST_WAIT_FC: begin
                        if (w_fc_edge) begin
                            if (r_firing_count != '1) r_firing_count <= r_firing_count + 1'b1;
                            r_remaining <= r_remaining - 1'b1;
                            r_state     <= (r_remaining > 1) ? c_ST_SETTLE : c_ST_IDLE;
                        end else if (TIMEOUT != 0) begin
                            if (r_timer == c_TMR_LAST) begin
                                r_timeout_err <= 1'b1;
                                r_state       <= c_ST_ERROR;
                            end else begin
                                r_timer <= r_timer + 1'b1;
                            end
                        end
                    end
                    c_ST_ERROR: if (err_clr) r_state <= c_ST_IDLE;
                    default:    r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pea_invoke_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_pea_invoke_scheduler
// Brief   : Directed and randomized bench against a descriptor-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_pea_invoke_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        desc_valid = 1'b0;
    logic        desc_ready;
    logic [1:0]  desc_mode = 2'b00;
    logic [7:0]  desc_count = 8'd0;
    logic        enable = 1'b0;
    logic        fc = 1'b0;
    logic        abort = 1'b0;
    logic        err_clr = 1'b0;
    logic [1:0]  next_mode;
    logic        invoke;
    logic        busy;
    logic [15:0] firing_count;
    logic        timeout_err;
    logic        bad_desc;

    pea_invoke_scheduler #(
        .DESC_DEPTH(4), .CNT_W(8), .TIMEOUT(16), .FIRE_CNT_W(16)
    ) dut (
        .clk(clk), .rst(rst), .desc_valid(desc_valid), .desc_ready(desc_ready),
        .desc_mode(desc_mode), .desc_count(desc_count), .enable(enable), .fc(fc),
        .abort(abort), .err_clr(err_clr), .next_mode(next_mode), .invoke(invoke),
        .busy(busy), .firing_count(firing_count), .timeout_err(timeout_err),
        .bad_desc(bad_desc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        int         rem;
    } desc_t;

    desc_t mq[$];
    int    exp_total;
    bit    exp_bad;
    int    n_checks = 0;
    int    n_pass   = 0;
    int    n_inv    = 0;
    int    fc_wait  = 0;
    bit    auto_fc  = 0;
    bit    prev_inv = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_push(input logic [1:0] m, input logic [7:0] c);
        desc_t d;
        if (m == 2'b11) begin
            exp_bad = 1;
        end else if (c != 0) begin
            d.mode = m;
            d.rem  = int'(c);
            mq.push_back(d);
            exp_total += int'(c);
        end
    endtask

    // One clock: record accepted push, drive auto fc, score any invoke.
    task automatic tick();
        bit acc;
        acc = desc_valid && desc_ready && !abort && !rst;
        @(posedge clk);
        #1;
        if (rst || abort) mq.delete();
        if (acc) model_push(desc_mode, desc_count);
        if (auto_fc) begin
            if (fc_wait > 0) begin
                fc_wait--;
                fc = (fc_wait == 0);
            end else begin
                fc = 1'b0;
            end
        end
        if (invoke) begin
            n_inv++;
            if (prev_inv) check("invoke_one_cycle", 1, 0);
            if (mq.size() == 0) begin
                check("unexpected_invoke", 1, 0);
            end else begin
                check("invoke_mode", 32'(next_mode), 32'(mq[0].mode));
                mq[0].rem = mq[0].rem - 1;
                if (mq[0].rem == 0) void'(mq.pop_front());
            end
            if (auto_fc) fc_wait = $urandom_range(1, 6);
        end
        prev_inv = invoke;
    endtask

    task automatic do_reset();
        rst = 1'b1; desc_valid = 1'b0; fc = 1'b0; abort = 1'b0; err_clr = 1'b0;
        fc_wait = 0; exp_total = 0; exp_bad = 0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [1:0] m, input logic [7:0] c);
        desc_valid = 1'b1; desc_mode = m; desc_count = c;
        tick();
        desc_valid = 1'b0;
    endtask

    task automatic wait_inv(input int max, output int lat);
        int start;
        start = n_inv;
        lat = 0;
        while (n_inv == start && lat < max) begin
            tick();
            lat++;
        end
        if (n_inv == start) check("invoke_wait_expired", 0, 1);
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((busy || fc_wait != 0 || fc) && k < 800) begin
            tick();
            k++;
        end
        if (k >= 800) check("drain_expired", 0, 1);
    endtask

    initial begin
        int lat;
        int base;
        int k;

        // Reset values
        do_reset();
        check("rst_next_mode", 32'(next_mode), 0);
        check("rst_invoke", 32'(invoke), 0);
        check("rst_firing_count", 32'(firing_count), 0);
        check("rst_timeout_err", 32'(timeout_err), 0);
        check("rst_bad_desc", 32'(bad_desc), 0);
        check("rst_desc_ready", 32'(desc_ready), 1);
        check("rst_busy", 32'(busy), 0);

        // Single firing, enable already high
        enable = 1'b1; auto_fc = 1;
        push(2'b01, 8'd1);
        wait_inv(20, lat);
        check("t1_latency", lat, 3);
        check("t1_next_mode", 32'(next_mode), 1);
        drain();
        check("t1_firing_count", 32'(firing_count), 1);
        check("t1_busy_after", 32'(busy), 0);

        // Three firings, fc held high between firings
        do_reset();
        enable = 1'b1; auto_fc = 0; base = n_inv;
        push(2'b00, 8'd3);
        wait_inv(20, lat);
        tick(); tick();
        fc = 1'b1;
        repeat (12) tick();
        check("t2_invokes_held_fc", n_inv - base, 2);
        check("t2_count_held_fc", 32'(firing_count), 1);
        fc = 1'b0; tick();
        fc = 1'b1;
        wait_inv(20, lat);
        check("t2_count_second_edge", 32'(firing_count), 2);
        fc = 1'b0; tick(); tick();
        fc = 1'b1; tick();
        fc = 1'b0; repeat (3) tick();
        check("t2_invokes", n_inv - base, 3);
        check("t2_firing_count", 32'(firing_count), 3);
        check("t2_busy_after", 32'(busy), 0);

        // Enable gating
        do_reset();
        enable = 1'b0; auto_fc = 1; base = n_inv;
        push(2'b10, 8'd1);
        repeat (10) tick();
        check("t3_no_early_invoke", n_inv - base, 0);
        enable = 1'b1;
        wait_inv(20, lat);
        check("t3_latency_after_enable", lat, 1);
        check("t3_next_mode", 32'(next_mode), 2);
        drain();
        check("t3_firing_count", 32'(firing_count), 1);

        // Timeout then err_clr resumes with the queued descriptor
        do_reset();
        enable = 1'b1; auto_fc = 0;
        push(2'b01, 8'd1);
        push(2'b01, 8'd1);
        wait_inv(20, lat);
        base = n_inv; k = 0;
        while (!timeout_err && k < 40) begin
            tick();
            k++;
        end
        check("t4_timeout_cycles", k, 17);
        check("t4_no_invoke_in_error", n_inv - base, 0);
        check("t4_busy_in_error", 32'(busy), 1);
        repeat (3) tick();
        check("t4_error_holds", n_inv - base, 0);
        check("t4_error_flag_sticky", 32'(timeout_err), 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        check("t4_err_clr", 32'(timeout_err), 0);
        auto_fc = 1;
        wait_inv(20, lat);
        check("t4_resume_mode", 32'(next_mode), 1);
        drain();
        check("t4_firing_count", 32'(firing_count), 1);

        // Queue full, reserved mode, zero count
        do_reset();
        enable = 1'b0; auto_fc = 1; base = n_inv;
        push(2'b01, 8'd1);
        check("t5_ready_before_fill", 32'(desc_ready), 1);
        push(2'b11, 8'd2);
        push(2'b01, 8'd0);
        push(2'b00, 8'd1);
        push(2'b10, 8'd2);
        check("t5_ready_full", 32'(desc_ready), 0);
        push(2'b01, 8'd1);
        check("t5_busy", 32'(busy), 1);
        enable = 1'b1;
        drain();
        check("t5_invokes", n_inv - base, 4);
        check("t5_firing_count", 32'(firing_count), 4);
        check("t5_bad_desc", 32'(bad_desc), 1);

        // Abort in WAIT_FC, then reset in WAIT_EN
        do_reset();
        enable = 1'b1; auto_fc = 0; base = n_inv;
        push(2'b01, 8'd2);
        push(2'b00, 8'd1);
        push(2'b10, 8'd1);
        wait_inv(20, lat);
        tick();
        fc = 1'b1; tick(); fc = 1'b0;
        wait_inv(20, lat);
        tick(); tick();
        check("t6_busy_before_abort", 32'(busy), 1);
        abort = 1'b1; tick(); abort = 1'b0;
        check("t6_busy_after_abort", 32'(busy), 0);
        check("t6_count_kept", 32'(firing_count), 1);
        fc = 1'b1; tick(); fc = 1'b0;
        repeat (8) tick();
        check("t6_no_invoke_after_abort", n_inv - base, 2);
        check("t6_fc_ignored_in_idle", 32'(firing_count), 1);
        push(2'b11, 8'd1);
        enable = 1'b0;
        push(2'b01, 8'd1);
        push(2'b00, 8'd2);
        repeat (3) tick();
        check("t6_bad_before_rst", 32'(bad_desc), 1);
        check("t6_busy_before_rst", 32'(busy), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        exp_total = 0; exp_bad = 0;
        check("t6_rst_busy", 32'(busy), 0);
        check("t6_rst_bad", 32'(bad_desc), 0);
        check("t6_rst_count", 32'(firing_count), 0);
        check("t6_rst_mode", 32'(next_mode), 0);
        check("t6_rst_ready", 32'(desc_ready), 1);
        repeat (5) tick();
        check("t6_rst_no_invoke", n_inv - base, 2);

        // Randomized traffic against the descriptor model
        do_reset();
        auto_fc = 1; base = n_inv;
        for (int i = 0; i < 400; i++) begin
            desc_valid = ($urandom % 2) == 0;
            desc_mode  = 2'($urandom_range(0, 3));
            desc_count = 8'($urandom_range(0, 3));
            enable     = ($urandom % 4) != 0;
            tick();
        end
        desc_valid = 1'b0;
        enable = 1'b1;
        drain();
        check("rnd_firing_count", 32'(firing_count), exp_total);
        check("rnd_invokes", n_inv - base, exp_total);
        check("rnd_bad_desc", 32'(bad_desc), 32'(exp_bad));
        check("rnd_timeout_err", 32'(timeout_err), 0);
        check("rnd_model_empty", mq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
